uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of uart_receiver.
- Consumes the receiver's rdy/data_out handshake, drives its rdy_clr, and stores bytes in a DEPTH-entry circular FIFO.
- Exposes a registered read port to the host, so received bytes are not lost between host polls.
- Flags dropped bytes with a sticky overrun bit.

Parameters:
DEPTH, 16, number of byte entries; power of two, 2..256
ADDR_W, 4, log2(DEPTH); pointer width
THRESH, 12, fill level for level_irq (used only with the optional feature); 1..DEPTH

Ports:
clk  input  1  system clock, shared with the baud generator and uart_receiver
rst  input  1  synchronous active-high reset
rx_data  input  8  byte from uart_receiver data_out
rx_rdy  input  1  uart_receiver rdy; high while a byte is valid
rdy_clr  output  1  to uart_receiver rdy_clr; registered
rd_en  input  1  host read strobe, one byte per cycle
rd_data  output  8  registered read data
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds DEPTH entries
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overrun  output  1  sticky: a byte was dropped because the FIFO was full
ovr_clr  input  1  clears overrun
level_irq  output  1  occupancy >= THRESH (optional feature)

Behaviour:
- Reset state: rst sampled high at a clk edge sets:
  - wr_ptr=0, rd_ptr=0, count=0
  - empty=1, full=0, overrun=0, rdy_clr=0, rd_data=8'h00, level_irq=0
  - capture FSM=IDLE
  - Memory contents are not cleared.
  - Reset mid-capture abandons the capture; FSM returns to IDLE with rdy_clr=0.
- Capture FSM, 2 states:
  - IDLE: rdy_clr=0. If rx_rdy=1 at an edge, rx_data is written on that same edge, or dropped if the FIFO cannot accept it. Next state is CLR.
  - CLR: rdy_clr=1. Stay while rx_rdy=1. When rx_rdy=0 is sampled, go to IDLE; rdy_clr falls on that edge.
  - Each receiver byte is captured exactly once, regardless of how many cycles rdy stays high.
  - Minimum capture spacing is 2 cycles.
- Write acceptance:
  - Accepted if full=0, or if full=1 and a valid read (rd_en=1) occurs in the same cycle.
  - On acceptance: mem[wr_ptr]<=rx_data; wr_ptr increments and wraps DEPTH-1 -> 0.
  - If not accepted: byte dropped, overrun<=1, pointers unchanged.
- Read:
  - rd_en=1 with empty=0: rd_data<=mem[rd_ptr] on that edge (1-cycle latency); rd_ptr increments with wrap.
  - rd_en=1 with empty=1: ignored; rd_data holds; no error flag.
  - rd_data holds its value between reads.
- Count:
  - +1 on write only, -1 on read only, unchanged on simultaneous write and read.
  - Never exceeds DEPTH and never goes below 0.
  - empty=(count==0), full=(count==DEPTH); both registered, updated with count.
- Overrun:
  - Set dominates clear: a drop and ovr_clr in the same cycle leaves overrun=1.
  - ovr_clr alone clears overrun on the next edge.
- Simultaneous write and read on an empty FIFO: the read is ignored (empty=1 at that edge); the write is accepted; count becomes 1.

Optional Feature:
- Macro UART_RX_FIFO_LEVEL_IRQ_EN.
- Defined: level_irq is a registered output, 1 when the next-state count >= THRESH, else 0. It asserts on the same edge where count reaches THRESH and deasserts on the edge where count drops below THRESH.
- Not defined: level_irq is tied to 0 and THRESH is unused; all other behaviour is identical.

Test Plan:
- Reset, then idle 10 cycles -> empty=1, full=0, count=0, rdy_clr=0, overrun=0, rd_data=8'h00.
- Single byte: rx_rdy high with rx_data=8'hA5, held 4 cycles, then low -> one write; rdy_clr high from cycle+1 until 1 cycle after rx_rdy falls; count=1; rd_en pulse gives rd_data=8'hA5 next cycle and empty=1.
- Fill 16 bytes 8'h00..8'h0F, then a 17th byte 8'hFF -> full=1, count=16, overrun=1, 8'hFF dropped; 16 reads return 8'h00..8'h0F in order; ovr_clr then gives overrun=0.
- Wrap: write 10, read 10, write 10, read 10 with distinct values -> order preserved across the pointer wrap; count never exceeds 10.
- Full plus simultaneous read and capture (rx_data=8'h77) -> count stays 16, overrun stays 0, and 8'h77 is the last byte read out.
- With UART_RX_FIFO_LEVEL_IRQ_EN defined and THRESH=12: level_irq rises on the 12th write and falls on the read that brings count to 11; with the macro undefined, level_irq stays 0 throughout.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO between uart_receiver and a polling host.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   rx_data, rx_rdy   byte and valid flag from uart_receiver
//   rdy_clr           registered acknowledge back to uart_receiver
//   rd_en, rd_data    host read strobe and registered read data (1-cycle latency)
//   empty, full       registered occupancy flags
//   count             occupancy 0..DEPTH
//   overrun, ovr_clr  sticky drop flag and its clear
//   level_irq         count >= THRESH, only when UART_RX_FIFO_LEVEL_IRQ_EN is defined
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int THRESH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    output logic              rdy_clr,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              level_irq
);
    typedef enum logic {IDLE, CLR} state_t;
    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
    state_t            state, state_nxt;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              capture, rd_ok, wr_ok;
    logic [ADDR_W:0]   count_nxt;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;

    // A byte is taken only on the IDLE->CLR transition, so a long rdy is captured once.
    always_comb begin
        state_nxt = IDLE;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                capture   = rx_rdy;
                state_nxt = rx_rdy ? CLR : IDLE;
            end
            CLR:     state_nxt = rx_rdy ? CLR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A read in the same cycle frees a slot, so a full FIFO can still accept.
    assign rd_ok     = rd_en && !empty;
    assign wr_ok     = capture && (!full || rd_ok);
    assign count_nxt = count + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);

    always_ff @(posedge clk)
        if (wr_ok)
            mem[wr_ptr] <= rx_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            overrun <= 1'b0;
            rdy_clr <= 1'b0;
            rd_data <= 8'h00;
        end else begin
            wr_ptr  <= wr_ok ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr  <= rd_ok ? rd_ptr + 1'b1 : rd_ptr;
            count   <= count_nxt;
            empty   <= count_nxt == '0;
            full    <= count_nxt == FULL_CNT;
            overrun <= (capture && !wr_ok) ? 1'b1 : ovr_clr ? 1'b0 : overrun;
            rdy_clr <= state_nxt == CLR;
            rd_data <= rd_ok ? mem[rd_ptr] : rd_data;
        end
    end

`ifdef UART_RX_FIFO_LEVEL_IRQ_EN
    localparam logic [ADDR_W:0] THRESH_CNT = THRESH[ADDR_W:0];
    always_ff @(posedge clk)
        level_irq <= rst ? 1'b0 : count_nxt >= THRESH_CNT;
`else
    assign level_irq = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed plus randomized check of uart_rx_fifo against a queue model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdy = 1'b0;
    logic       rdy_clr;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full, overrun, level_irq;
    logic       ovr_clr = 1'b0;
    logic [4:0] count;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] q[$];
    logic       m_busy = 1'b0;
    logic       m_ovr = 1'b0;
    logic [7:0] m_rd = 8'h00;

    uart_rx_fifo dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .rdy_clr(rdy_clr),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .count(count),
        .overrun(overrun), .ovr_clr(ovr_clr), .level_irq(level_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    // Apply inputs for one cycle, advance the model across the edge, then compare.
    task automatic step(input logic rdy, input logic [7:0] d, input logic rd, input logic oc);
        logic cap, rok, acc;
        int   lvl;
        rx_rdy  = rdy;
        rx_data = d;
        rd_en   = rd;
        ovr_clr = oc;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_busy = 1'b0;
            m_ovr  = 1'b0;
            m_rd   = 8'h00;
        end else begin
            cap = rdy && !m_busy;
            rok = rd && q.size() > 0;
            acc = cap && (q.size() < DEPTH || rok);
            if (rok) m_rd = q.pop_front();
            if (acc) q.push_back(d);
            m_ovr  = (cap && !acc) ? 1'b1 : oc ? 1'b0 : m_ovr;
            m_busy = rdy;
        end
`ifdef UART_RX_FIFO_LEVEL_IRQ_EN
        lvl = q.size() >= 12 ? 1 : 0;
`else
        lvl = 0;
`endif
        #1;
        chk("count", int'(count), q.size());
        chk("empty", int'(empty), q.size() == 0 ? 1 : 0);
        chk("full", int'(full), q.size() == DEPTH ? 1 : 0);
        chk("overrun", int'(overrun), int'(m_ovr));
        chk("rdy_clr", int'(rdy_clr), int'(m_busy));
        chk("rd_data", int'(rd_data), int'(m_rd));
        chk("level_irq", int'(level_irq), lvl);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic put(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic get();
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("reset_rd_data", int'(rd_data), 8'h00);

        for (int i = 0; i < 4; i++) step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("single_count", int'(count), 1);
        get();
        chk("single_byte", int'(rd_data), 8'hA5);
        chk("single_empty", int'(empty), 1);

        do_reset();
        for (int i = 0; i < 16; i++) put(8'(i));
        put(8'hFF);
        chk("fill_full", int'(full), 1);
        chk("fill_ovr", int'(overrun), 1);
        for (int i = 0; i < 16; i++) begin
            get();
            chk("fill_order", int'(rd_data), i);
        end
        get();
        chk("empty_read_hold", int'(rd_data), 8'h0F);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovr_cleared", int'(overrun), 0);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) put(8'(8'h30 + r * 16 + i));
            for (int i = 0; i < 10; i++) begin
                get();
                chk("wrap_order", int'(rd_data), 8'h30 + r * 16 + i);
            end
        end

        do_reset();
        for (int i = 0; i < 16; i++) put(8'(8'h40 + i));
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("full_rw_count", int'(count), 16);
        chk("full_rw_ovr", int'(overrun), 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) get();
        chk("full_rw_last", int'(rd_data), 8'h77);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int ph;
            ph  = (i / 250) % 3;
            rst = ($urandom_range(0, 499) == 0);
            step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) < ph + 1,
                 $urandom_range(0, 19) == 0);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
